// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and stall request.
// Divide datapath is built only when MULDIV_DIVIDE_EN is defined; otherwise DIV/DIVU act as no-ops.
module muldiv_unit #(
  parameter int DATA_SIZE = 32,
  parameter int OP_SIZE = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [OP_SIZE-1:0]   i_op,
  input  logic [DATA_SIZE-1:0] i_A,
  input  logic [DATA_SIZE-1:0] i_B,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_div_by_zero,
  output logic [DATA_SIZE-1:0] o_hi,
  output logic [DATA_SIZE-1:0] o_lo
);
  localparam int W = DATA_SIZE;
  localparam int CW = $clog2(W);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, mul_next;
  logic [W-1:0] mcand, a_mag, b_mag;
  logic [W:0] msum;
  logic neg_res, mul_op, a_neg, b_neg, dz_pulse;
  assign mul_op = i_op == OP_SIZE'(0) || i_op == OP_SIZE'(1);
  assign a_neg = i_op[0] & i_A[W-1];
  assign b_neg = i_op[0] & i_B[W-1];
  assign a_mag = a_neg ? -i_A : i_A;
  assign b_mag = b_neg ? -i_B : i_B;
  assign o_busy = state == RUN || state == FIX;
  assign o_div_by_zero = dz_pulse;
  // acc holds {partial product, remaining multiplier bits}, shifted right each step
  assign msum = {1'b0, acc[2*W-1:W]} + {1'b0, acc[0] ? mcand : {W{1'b0}}};
  assign mul_next = {msum, acc[W-1:1]};
`ifdef MULDIV_DIVIDE_EN
  logic is_div, neg_rem, dbz, qbit, div_op;
  logic [W:0] rem_t, diff;
  logic [2*W-1:0] div_next;
  assign div_op = i_op == OP_SIZE'(2) || i_op == OP_SIZE'(3);
  // acc holds {remainder, dividend bits shifting into quotient}
  assign rem_t = {acc[2*W-1:W], acc[W-1]};
  assign diff = rem_t - {1'b0, mcand};
  assign qbit = ~diff[W];
  assign div_next = {qbit ? diff[W-1:0] : rem_t[W-1:0], acc[W-2:0], qbit};
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) dz_pulse <= 1'b0;
    else dz_pulse <= state == FIX && is_div && dbz;
`else
  assign dz_pulse = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      neg_res <= 1'b0;
      o_done <= 1'b0;
      o_hi <= '0;
      o_lo <= '0;
`ifdef MULDIV_DIVIDE_EN
      is_div <= 1'b0;
      neg_rem <= 1'b0;
      dbz <= 1'b0;
`endif
    end else begin
      o_done <= state == FIX;
      if (state == IDLE && i_start) begin
        neg_res <= a_neg ^ b_neg;
        cnt <= CW'(W - 1);
        if (mul_op) begin
          state <= RUN;
          acc <= {{W{1'b0}}, b_mag};
          mcand <= a_mag;
`ifdef MULDIV_DIVIDE_EN
          is_div <= 1'b0;
`endif
        end
`ifdef MULDIV_DIVIDE_EN
        else if (div_op) begin
          is_div <= 1'b1;
          neg_rem <= a_neg;
          dbz <= i_B == '0;
          state <= i_B == '0 ? FIX : RUN;
          acc <= {{W{1'b0}}, i_B == '0 ? i_A : a_mag};
          mcand <= b_mag;
        end
`endif
        else if (i_op == OP_SIZE'(4)) o_hi <= i_A;
        else if (i_op == OP_SIZE'(5)) o_lo <= i_A;
      end else if (state == RUN) begin
`ifdef MULDIV_DIVIDE_EN
        acc <= is_div ? div_next : mul_next;
`else
        acc <= mul_next;
`endif
        cnt <= cnt - 1'b1;
        if (cnt == '0) state <= FIX;
      end else if (state == FIX) begin
        state <= IDLE;
`ifdef MULDIV_DIVIDE_EN
        if (is_div) begin
          o_hi <= dbz ? acc[W-1:0] : neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
          o_lo <= dbz ? {W{1'b1}} : neg_res ? -acc[W-1:0] : acc[W-1:0];
        end else
`endif
        {o_hi, o_lo} <= neg_res ? -acc : acc;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic i_clk = 0, i_reset = 1, i_start = 0;
  logic [2:0] i_op = 0;
  logic [31:0] i_A = 0, i_B = 0;
  logic o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo;
  logic [31:0] m_hi = 0, m_lo = 0;
  int vectors = 0, errs = 0;

  muldiv_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_A(i_A), .i_B(i_B), .o_busy(o_busy), .o_done(o_done),
    .o_div_by_zero(o_div_by_zero), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit div_en();
`ifdef MULDIV_DIVIDE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int exp_busy, output bit exp_done, output bit exp_dz);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] p;
    exp_busy = 0; exp_done = 0; exp_dz = 0;
    case (op)
      0: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; exp_busy = 33; exp_done = 1; end
      1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; exp_busy = 33; exp_done = 1; end
      2, 3: if (div_en()) begin
        exp_done = 1;
        if (b == 0) begin m_hi = a; m_lo = '1; exp_busy = 1; exp_dz = 1; end
        else begin
          exp_busy = 33;
          if (op == 2) begin m_lo = a / b; m_hi = a % b; end
          else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
        end
      end
      4: m_hi = a;
      5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input bit now, input int inj);
    int eb, nb;
    bit ed, edz, got, dz;
    if (!now) @(negedge i_clk);
    i_start = 1; i_op = op; i_A = a; i_B = b;
    model(op, a, b, eb, ed, edz);
    @(negedge i_clk);
    i_start = 0; i_A = $urandom; i_B = $urandom;
    nb = 0; got = 0; dz = 0;
    for (int c = 0; c < (ed ? 60 : 4) && !got; c++) begin
      if (o_busy) nb++;
      if (o_div_by_zero) dz = 1;
      if (o_done) got = 1;
      else begin
        if (c == inj) begin i_start = 1; i_op = 3'd4; i_A = 32'hDEADBEEF; end
        @(negedge i_clk);
        i_start = 0;
      end
    end
    chk({tag, " done"}, got, ed);
    chk({tag, " busy"}, nb, eb);
    chk({tag, " dz"}, dz, edz);
    chk({tag, " hi"}, o_hi, m_hi);
    chk({tag, " lo"}, o_lo, m_lo);
  endtask

  initial begin
    logic [31:0] sp [4];
    logic [31:0] a, b;
    logic [2:0] op;
    sp[0] = 0; sp[1] = 1; sp[2] = 32'hFFFFFFFF; sp[3] = 32'h80000000;
    i_start = 1; i_op = 3'd4; i_A = 32'hDEADBEEF;
    repeat (2) @(negedge i_clk);
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset dz", o_div_by_zero, 0);
    chk("reset hi", o_hi, 0);
    chk("reset lo", o_lo, 0);
    i_reset = 0; i_start = 0;

    run("multu max", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1);
    chk("multu max hi const", o_hi, 32'hFFFFFFFE);
    chk("multu max lo const", o_lo, 32'h00000001);
    @(negedge i_clk);
    chk("multu done pulse", o_done, 0);
    chk("multu busy after", o_busy, 0);
    run("mult neg", 1, 32'hFFFFFFFD, 7, 0, -1);
    chk("mult neg lo const", o_lo, 32'hFFFFFFEB);
    run("div -7/2", 3, 32'hFFFFFFF9, 2, 0, -1);
    run("divu 7/2", 2, 7, 2, 0, -1);
    run("div by zero", 3, 32'h12345678, 0, 0, -1);
    run("div ovf", 3, 32'h80000000, 32'hFFFFFFFF, 0, -1);
    run("mthi", 4, 32'hCAFEBABE, 0, 0, -1);
    run("mtlo", 5, 1, 0, 1, -1);
    run("mult inject", 0, 5, 9, 0, 5);
    chk("inject hi kept", o_hi, 0);
    run("b2b first", 1, 32'h80000000, 32'h80000000, 0, -1);
    run("b2b second", 0, 32'h10001, 32'h30003, 1, -1);
    run("noop 6", 6, 32'h55, 32'h66, 0, -1);

    @(negedge i_clk);
    i_start = 1; i_op = 3'd1; i_A = 32'hFFFFFFFD; i_B = 7;
    @(negedge i_clk);
    i_start = 0;
    repeat (9) @(negedge i_clk);
    chk("pre-reset busy", o_busy, 1);
    #2 i_reset = 1;
    #1;
    chk("async reset busy", o_busy, 0);
    chk("async reset hi", o_hi, 0);
    chk("async reset lo", o_lo, 0);
    m_hi = 0; m_lo = 0;
    @(negedge i_clk);
    i_reset = 0;
    repeat (3) @(negedge i_clk);
    chk("post-reset idle", o_busy, 0);
    run("post-reset multu", 0, 2, 3, 0, -1);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      run("random", op, a, b, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the EX stage and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The ALU result path stays single-cycle; this block runs for many cycles and drives the stall request that freezes IF/ID/EX while it computes. MFHI/MFLO read `o_hi`/`o_lo` directly through the EX result mux.

## Interface
Parameters:
- `DATA_SIZE`, 32: operand and HI/LO width.
- `OP_SIZE`, 3: width of `i_op`.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_start`, in, 1: request to execute `i_op` this cycle.
- `i_op`, in, `OP_SIZE`: operation select.
  - 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO.
  - 6 and 7 are no-ops.
- `i_A`, in, `DATA_SIZE`: rs value (multiplicand / dividend / MTxx source).
- `i_B`, in, `DATA_SIZE`: rt value (multiplier / divisor).
- `o_busy`, out, 1: unit occupied; pipeline stall request.
- `o_done`, out, 1: one-cycle pulse; HI/LO hold the new result.
- `o_div_by_zero`, out, 1: one-cycle pulse, coincident with `o_done`, for a DIV/DIVU with `i_B == 0`.
- `o_hi`, out, `DATA_SIZE`: HI register.
- `o_lo`, out, `DATA_SIZE`: LO register.

## Operation
- States: IDLE, RUN, FIX.
- Operands are latched at the accepting edge. `i_A`/`i_B` may change afterwards.

Start handling:
- `i_start` is sampled only in IDLE. While `o_busy` is high it is ignored; no queueing.

IDLE, on `i_start`:
- MULT/MULTU → RUN, counter = `DATA_SIZE`-1.
- DIV/DIVU with `i_B != 0` → RUN, counter = `DATA_SIZE`-1.
- DIV/DIVU with `i_B == 0` → FIX directly.
- MTHI/MTLO: write `i_A` to HI or LO at that edge. State stays IDLE; no busy, no done.
- ops 6/7: no effect.

Signed handling:
- For MULT/DIV, operands are converted to magnitudes at latch time and the result sign flags are stored.
- Unsigned ops store positive sign flags.

RUN, one bit per cycle:
- Multiply: shift-add into a 2·`DATA_SIZE` accumulator.
- Divide: restoring shift-subtract, producing quotient and remainder.
- Counter at 0 → FIX.

FIX, one cycle:
- Apply sign correction and write HI/LO. → IDLE.
- Multiply: {HI,LO} = 64-bit product, two's-complement negated if the operand signs differ.
- Divide: LO = quotient, negated if the signs differ. HI = remainder, taking the sign of the dividend.
- Divide by zero: HI = dividend `i_A` unchanged, LO = all ones. `o_div_by_zero` pulses.
- DIV of -2^(`DATA_SIZE`-1) by -1: LO = 0x80000000 (wraps), HI = 0. No flag.

Outputs:
- `o_busy` = state is RUN or FIX (combinational from state).
- `o_done` and `o_div_by_zero` are registered. They are high for exactly the first IDLE cycle after FIX.
- HI/LO change only in FIX or on MTHI/MTLO. Otherwise they hold.

Reset (asynchronous, may occur mid-operation):
- State → IDLE; any in-flight operation is aborted and discarded.
- HI = 0, LO = 0, `o_busy` = 0, `o_done` = 0, `o_div_by_zero` = 0.

## Timing
- MULT/DIV latency: operation accepted at edge k; `o_busy` high in cycles k+1..k+`DATA_SIZE`+1, i.e. 32 RUN cycles plus 1 FIX; HI/LO valid and `o_done` high in cycle k+`DATA_SIZE`+2.
- Divide-by-zero: `o_busy` for 1 cycle (FIX only). `o_done` and `o_div_by_zero` high in cycle k+2.
- MTHI/MTLO: HI/LO visible in cycle k+1.
- Back-to-back: a new `i_start` is accepted in the same cycle `o_done` is high.
- `i_start` coincident with reset release: ignored while `i_reset` is high.

## Configuration
- Macro `MULDIV_DIVIDE_EN`.
- Defined: DIV/DIVU are implemented as above.
- Undefined: the divide datapath is not built. DIV/DIVU are treated as no-ops: no busy, no done, HI/LO unchanged, `o_div_by_zero` held at 0. Multiply and MTxx behaviour is unchanged.

## Test plan
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF → after 34 cycles, HI=0xFFFFFFFE, LO=0x00000001; `o_busy` high for exactly 33 cycles; single `o_done` pulse.
- MULT with A=-3 (0xFFFFFFFD), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV with A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU with A=7, B=2 → LO=3, HI=1.
- DIV with A=0x12345678, B=0 → `o_busy` 1 cycle; HI=0x12345678, LO=0xFFFFFFFF; `o_div_by_zero` and `o_done` pulse together.
- MTHI with A=0xCAFEBABE, then MTLO with A=0x1 on consecutive cycles → HI=0xCAFEBABE, LO=1; `o_busy` never asserted. A second `i_start` issued mid-MULT is ignored.
- Assert `i_reset` at RUN cycle 10 → outputs zero immediately, state IDLE; a MULTU 2×3 issued after release gives LO=6, HI=0.
